// File: rtl/sched_pkg.sv
// Shared scheduler definitions: default element geometry, field offsets,
// post-dequeue state encoding and the invalid-element sentinel.
package sched_pkg;

   localparam int SCHED_NUM_FIFO      = 3;
   localparam int SCHED_ID_LOG        = $clog2(SCHED_NUM_FIFO);
   localparam int SCHED_RANK_LOG      = 1;
   localparam int SCHED_TIME_LOG      = 1;
   localparam int SCHED_ELEMENT_WIDTH = SCHED_ID_LOG + SCHED_RANK_LOG + SCHED_TIME_LOG;

   // Element layout is {id, rank, time}; time always sits at bit 0.
   localparam int SCHED_TIME_OFS = 0;
   localparam int SCHED_RANK_OFS = SCHED_TIME_OFS + SCHED_TIME_LOG;
   localparam int SCHED_ID_OFS   = SCHED_RANK_OFS + SCHED_RANK_LOG;

   localparam logic [SCHED_ELEMENT_WIDTH-1:0] SCHED_INVALID_ELEMENT = {SCHED_ELEMENT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_REQ       = 2'd1,
      ST_WAIT_DONE = 2'd2
   } sched_state_e;

endpackage

// File: rtl/sched_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sched_sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] value
);

   // Count up on inc until saturated; clear has priority.
   always_ff @(posedge clk) begin
      if (clear) begin
         value <= {CNT_WIDTH{1'b0}};
      end else if (inc && (value != {CNT_WIDTH{1'b1}})) begin
         value <= value + CNT_WIDTH'(1);
      end else begin
         value <= value;
      end
   end

endmodule

// File: rtl/sched_post_deq_dispatch.sv
// Post-dequeue dispatcher: decodes one scheduler element, requests transmit on
// the selected per-flow queue and waits for its done (or a timeout).
module sched_post_deq_dispatch
   import sched_pkg::*;
#(
   parameter int NUM_FIFO       = SCHED_NUM_FIFO,
   parameter int ID_LOG         = $clog2(NUM_FIFO),
   parameter int RANK_LOG       = SCHED_RANK_LOG,
   parameter int TIME_LOG       = SCHED_TIME_LOG,
   parameter int ELEMENT_WIDTH  = ID_LOG + RANK_LOG + TIME_LOG,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          deq_valid_in,
   input  logic [ELEMENT_WIDTH-1:0]      deq_element_in,
   output logic                          post_deq_ready,
   output logic                          tx_req_valid,
   output logic [ID_LOG-1:0]             tx_req_id,
   output logic [RANK_LOG-1:0]           tx_req_rank,
   output logic [TIME_LOG-1:0]           tx_req_time,
   input  logic                          tx_req_ready,
   input  logic                          tx_done,
   input  logic [ID_LOG-1:0]             tx_done_id,
   output logic                          busy,
   output logic [NUM_FIFO*CNT_WIDTH-1:0] dispatch_count,
   output logic [CNT_WIDTH-1:0]          drop_count,
   output logic [CNT_WIDTH-1:0]          timeout_count
);

   localparam int TIME_OFS = SCHED_TIME_OFS;
   localparam int RANK_OFS = TIME_OFS + TIME_LOG;
   localparam int ID_OFS   = RANK_OFS + RANK_LOG;
   localparam int TMR_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ID_LOG:0]   NUM_FIFO_L = (ID_LOG + 1)'(NUM_FIFO);

   sched_state_e          state_r;
   logic [ID_LOG-1:0]     id_r;
   logic [TMR_W-1:0]      timer_r;
   logic [ID_LOG-1:0]     elem_id_s;
   logic                  accept_s;
   logic                  in_range_s;
   logic                  hs_s;
   logic                  done_match_s;
   logic                  expire_s;
   logic [NUM_FIFO-1:0]   disp_inc_s;

   assign post_deq_ready = (state_r == ST_IDLE) && !rst;
   assign elem_id_s      = deq_element_in[ID_OFS +: ID_LOG];
   assign accept_s       = deq_valid_in && post_deq_ready;
   assign in_range_s     = {1'b0, elem_id_s} < NUM_FIFO_L;
   assign hs_s           = (state_r == ST_REQ) && tx_req_valid && tx_req_ready;
   assign done_match_s   = (state_r == ST_WAIT_DONE) && tx_done && (tx_done_id == id_r);
   assign expire_s       = (state_r == ST_WAIT_DONE) && (timer_r == TMR_LAST);

   // Dispatch FSM; request fields are registered and zero outside REQ.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         id_r         <= {ID_LOG{1'b0}};
         timer_r      <= {TMR_W{1'b0}};
         tx_req_valid <= 1'b0;
         tx_req_id    <= {ID_LOG{1'b0}};
         tx_req_rank  <= {RANK_LOG{1'b0}};
         tx_req_time  <= {TIME_LOG{1'b0}};
         busy         <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s && in_range_s) begin
                  state_r      <= ST_REQ;
                  id_r         <= elem_id_s;
                  tx_req_valid <= 1'b1;
                  tx_req_id    <= elem_id_s;
                  tx_req_rank  <= deq_element_in[RANK_OFS +: RANK_LOG];
                  tx_req_time  <= deq_element_in[TIME_OFS +: TIME_LOG];
                  busy         <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (hs_s) begin
                  state_r      <= ST_WAIT_DONE;
                  timer_r      <= {TMR_W{1'b0}};
                  tx_req_valid <= 1'b0;
                  tx_req_id    <= {ID_LOG{1'b0}};
                  tx_req_rank  <= {RANK_LOG{1'b0}};
                  tx_req_time  <= {TIME_LOG{1'b0}};
               end else begin
                  state_r <= ST_REQ;
               end
            end
            ST_WAIT_DONE: begin
               // A matching done and expiry both return to IDLE; the
               // timeout counter alone decides which one is recorded.
               if (done_match_s || expire_s) begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
               end else begin
                  timer_r <= timer_r + TMR_W'(1);
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               tx_req_valid <= 1'b0;
               tx_req_id    <= {ID_LOG{1'b0}};
               tx_req_rank  <= {RANK_LOG{1'b0}};
               tx_req_time  <= {TIME_LOG{1'b0}};
               busy         <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_FIFO; i++) begin : g_disp
      assign disp_inc_s[i] = hs_s && (id_r == ID_LOG'(i));

      sched_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_disp_cnt (
         .clk   (clk),
         .clear (rst),
         .inc   (disp_inc_s[i]),
         .value (dispatch_count[i*CNT_WIDTH +: CNT_WIDTH])
      );
   end

   sched_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (accept_s && !in_range_s),
      .value (drop_count)
   );

   sched_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_timeout_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (expire_s && !done_match_s),
      .value (timeout_count)
   );

endmodule

// File: doc/sched_post_deq_dispatch.md
Name: sched_post_deq_dispatch

Overview:
- Post-dequeue stage directly downstream of the scheduler FIFO buffer.
- Accepts one dequeued scheduler element at a time and decodes its FIFO ID, rank and time fields.
- Issues a transmit request to the selected per-flow queue, then waits for that queue's transmit-done before accepting the next element.
- Keeps saturating statistics: dispatches per FIFO, dropped elements, timeouts.

Parameters:
NUM_FIFO, 3, number of per-flow queues
ID_LOG, $clog2(NUM_FIFO), FIFO ID field width
RANK_LOG, 1, rank field width
TIME_LOG, 1, time field width
ELEMENT_WIDTH, ID_LOG+RANK_LOG+TIME_LOG, element width
TIMEOUT_CYCLES, 16, max WAIT_DONE cycles before abandoning (>=2)
CNT_WIDTH, 16, statistics counter width

Ports:
clk  in  1  clock
rst  in  1  reset
deq_valid_in  in  1  element valid from buffer
deq_element_in  in  ELEMENT_WIDTH  element {id, rank, time}, id in MSBs, time in LSBs
post_deq_ready  out  1  block can accept an element this cycle
tx_req_valid  out  1  transmit request valid
tx_req_id  out  ID_LOG  target queue
tx_req_rank  out  RANK_LOG  rank of dispatched element
tx_req_time  out  TIME_LOG  time of dispatched element
tx_req_ready  in  1  queue accepts request
tx_done  in  1  transmit completed pulse
tx_done_id  in  ID_LOG  queue reporting completion
busy  out  1  state != IDLE
dispatch_count  out  NUM_FIFO*CNT_WIDTH  per-FIFO dispatch count, FIFO i at bits [i*CNT_WIDTH +: CNT_WIDTH]
drop_count  out  CNT_WIDTH  elements with id >= NUM_FIFO
timeout_count  out  CNT_WIDTH  WAIT_DONE timeouts

Behaviour:
- Reset: clk is the clock; rst is synchronous, active-high.
  - On reset: state IDLE; held element, timer and all counters cleared.
  - post_deq_ready = 0 while rst is high; tx_req_* = 0, busy = 0.
  - Reset mid-operation abandons the held element without counting it.
- post_deq_ready is combinational: (state == IDLE) && !rst.
- Accept occurs when deq_valid_in && post_deq_ready. deq_valid_in while not ready is ignored; the buffer only asserts valid when ready.
- IDLE:
  - Accept with id < NUM_FIFO: capture id/rank/time and move to REQ next cycle.
  - Accept with id >= NUM_FIFO: drop_count += 1 and stay in IDLE.
- REQ:
  - tx_req_valid = 1 (registered); tx_req_id/rank/time = captured fields, held stable until handshake.
  - On tx_req_valid && tx_req_ready: dispatch_count[id] += 1, go to WAIT_DONE, timer = 0.
  - Minimum latency accept->request is 1 cycle.
  - tx_done seen in REQ is ignored.
- WAIT_DONE:
  - tx_req_valid = 0; timer increments each cycle.
  - tx_done && tx_done_id == captured id: IDLE next cycle.
  - tx_done with a different id: ignored.
  - timer == TIMEOUT_CYCLES-1 with no matching done: timeout_count += 1, go to IDLE.
  - Matching done in the same cycle as expiry: done wins, no timeout counted.
- Throughput: at most one element per (1 + request wait + done wait + 1) cycles. There is no skid; the buffer holds back-pressured elements.
- Counters saturate at all-ones and never wrap.
- Outside REQ, tx_req_* data outputs are 0.

Decomposition:
- Shared package sched_pkg holds:
  - element field slicing constants (ID/RANK/TIME offsets and widths);
  - state encoding IDLE=0, REQ=1, WAIT_DONE=2;
  - the all-ones invalid-element sentinel constant, shared with the buffer.
- One sub-module: sched_sat_counter (CNT_WIDTH, inc, clear, value), instantiated NUM_FIFO+2 times.

Test Plan (defaults; ELEMENT_WIDTH=4, ID_LOG=2):
- Reset then idle -> post_deq_ready=1 the first cycle after rst falls; all counts 0; tx_req_valid=0.
- Accept 4'b0110, tx_req_ready=1 immediately, tx_done id=1 three cycles later:
  - tx_req_valid one cycle after accept, with id=1, rank=1, time=0;
  - dispatch_count[1]=1; post_deq_ready returns the cycle after done.
- Accept 4'b1100 (id=3) -> no request; drop_count=1; post_deq_ready stays 1.
- Accept id=2, hold tx_req_ready=0 for 5 cycles -> request fields stable all 5 cycles; a single dispatch_count[2] increment on handshake.
- Accept id=0, handshake, never send done (send tx_done id=2 mid-wait) -> timeout_count=1 exactly 16 cycles after WAIT_DONE entry; mismatched done ignored.
- Matching done on the expiry cycle -> timeout_count unchanged; IDLE next cycle. Separately, assert rst while in WAIT_DONE -> IDLE, counters 0, post_deq_ready=1 after release.
